load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns stores onto byte lanes, extends loads, and runs a single
// outstanding bus transfer with an ack timeout. Misaligned accesses fault without touching the bus.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        ld_misaligned,
  output logic        st_misaligned,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  lane_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        load_q;
  logic [2:0]  rd_type_q;
  logic [31:0] rdata_q;

  logic        is_store;
  logic        idle;
  logic        busy;
  logic        st_mis_c;
  logic        ld_mis_c;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_data_c;

  // A store encoding wins over is_load when both are present.
  assign is_store = mem_write != 2'b00;
  assign idle     = state_q == StIdle;
  assign busy     = state_q == StBusy;

  always_comb begin
    st_mis_c = 1'b0;
    case (mem_write)
      2'b10:   st_mis_c = addr[0];
      2'b11:   st_mis_c = addr[1:0] != 2'b00;
      default: st_mis_c = 1'b0;
    endcase
  end

  always_comb begin
    ld_mis_c = 1'b0;
    case (mem_read)
      3'b001, 3'b011: ld_mis_c = 1'b0;
      3'b010, 3'b100: ld_mis_c = addr[0];
      default:        ld_mis_c = addr[1:0] != 2'b00;
    endcase
  end

  // rst_n gating keeps the combinational outputs low while reset is held.
  assign st_misaligned = rst_n & idle & req_valid & is_store & st_mis_c;
  assign ld_misaligned = rst_n & idle & req_valid & ~is_store & is_load & ld_mis_c;
  assign accept        = rst_n & idle & req_valid & (is_store ? ~st_mis_c : (is_load & ~ld_mis_c));

  assign timeout_hit = busy & (cnt_q == 8'hFF);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = 32'h0;
    case (mem_write)
      2'b01: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b10: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      2'b11: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
      end
    endcase
  end

  assign shifted_c = bus_rdata >> {lane_q, 3'b000};
  assign byte_c    = shifted_c[7:0];
  assign half_c    = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    load_data_c = bus_rdata;
    case (rd_type_q)
      3'b001:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b010:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b011:  load_data_c = {24'h0, byte_c};
      3'b100:  load_data_c = {16'h0, half_c};
      default: load_data_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'h0;
      addr_q    <= 32'h0;
      lane_q    <= 2'b00;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      rd_type_q <= 3'b000;
      rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StBusy;
            cnt_q     <= 8'h0;
            addr_q    <= {addr[31:2], 2'b00};
            lane_q    <= addr[1:0];
            be_q      <= be_c;
            wdata_q   <= wdata_c;
            we_q      <= is_store;
            load_q    <= ~is_store;
            rd_type_q <= mem_read;
          end
        end
        StBusy: begin
          if (timeout_hit) begin
            state_q <= StDone;
            if (load_q) rdata_q <= 32'h0;
          end else if (bus_ack) begin
            state_q <= StDone;
            if (load_q) rdata_q <= load_data_c;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall       = accept | busy;
  assign bus_req     = busy & ~timeout_hit;
  assign bus_timeout = timeout_hit;
  assign bus_we      = busy & we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign rdata_out   = rdata_q;
  assign rdata_valid = (state_q == StDone) & load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane placement, load extension, faults, timeout, reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        is_load;
  logic [1:0]  mem_write;
  logic [2:0]  mem_read;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        ld_misaligned;
  logic        st_misaligned;
  logic        bus_timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .is_load       (is_load),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .rdata_out     (rdata_out),
    .rdata_valid   (rdata_valid),
    .ld_misaligned (ld_misaligned),
    .st_misaligned (st_misaligned),
    .bus_timeout   (bus_timeout),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Negedge monitor: inputs change at posedge+1, so these samples are race-free.
  int          stall_cyc = 0;
  int          req_cyc   = 0;
  int          xfers     = 0;
  int          rv_cnt    = 0;
  int          to_cnt    = 0;
  logic [31:0] last_addr  = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_be    = 4'h0;
  logic        last_we    = 1'b0;

  always @(negedge clk) begin
    if (stall) stall_cyc++;
    if (bus_req) req_cyc++;
    if (rdata_valid) rv_cnt++;
    if (bus_timeout) to_cnt++;
    if (bus_req && bus_ack) begin
      xfers++;
      last_addr  = bus_addr;
      last_wdata = bus_wdata;
      last_be    = bus_be;
      last_we    = bus_we;
    end
  end

  logic [31:0] done_rdata;
  logic        done_rv;
  logic        done_stall;
  int          busy_cycles;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: IDLE cycle, BUSY until ack after 'waits' cycles (negative = never), then DONE.
  task automatic access(input logic [1:0] mw, input logic [2:0] mr, input logic ld,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input bit hold);
    int n;
    req_valid = 1'b1;
    mem_write = mw;
    mem_read  = mr;
    is_load   = ld;
    addr      = a;
    wdata     = wd;
    bus_rdata = rd;
    bus_ack   = 1'b0;
    step();
    n = 0;
    while (stall && n < 400) begin
      bus_ack = (n == waits);
      step();
      bus_ack = 1'b0;
      n++;
    end
    busy_cycles = n;
    check("busy_bound", {31'b0, n < 400}, 32'd1);
    done_rdata = rdata_out;
    done_rv    = rdata_valid;
    done_stall = stall;
    if (!hold) req_valid = 1'b0;
    step();
  endtask

  int s0, r0, x0, v0, t0;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    is_load   = 1'b1;
    mem_write = 2'b00;
    mem_read  = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    #12;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_be", {28'b0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_rdata_out", rdata_out, 32'h0);
    check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // sb with two wait cycles
    s0 = stall_cyc; x0 = xfers;
    access(2'b01, 3'b000, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 2, 1'b0);
    check("sb_be", {28'b0, last_be}, 32'h8);
    check("sb_addr", last_addr, 32'h1000);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    check("sb_we", {31'b0, last_we}, 32'd1);
    check("sb_stall_cycles", 32'(stall_cyc - s0), 32'd4);
    check("sb_xfers", 32'(xfers - x0), 32'd1);
    check("sb_no_rvalid", {31'b0, done_rv}, 32'd0);

    // loads with extension
    access(2'b00, 3'b001, 1'b1, 32'h2001, 32'h0, 32'h0000_8000, 0, 1'b0);
    check("lb_data", done_rdata, 32'hFFFF_FF80);
    check("lb_rvalid", {31'b0, done_rv}, 32'd1);
    check("lb_be", {28'b0, last_be}, 32'hF);
    check("lb_we", {31'b0, last_we}, 32'd0);
    check("lb_rvalid_drop", {31'b0, rdata_valid}, 32'd0);
    access(2'b00, 3'b011, 1'b1, 32'h2001, 32'h0, 32'h0000_8000, 1, 1'b0);
    check("lbu_data", done_rdata, 32'h0000_0080);
    access(2'b00, 3'b100, 1'b1, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    check("lhu_data", done_rdata, 32'h0000_BEEF);
    access(2'b00, 3'b010, 1'b1, 32'h2002, 32'h0, 32'h8001_0000, 0, 1'b0);
    check("lh_data", done_rdata, 32'hFFFF_8001);

    // lw latency: IDLE + one BUSY cycle of stall, then DONE
    s0 = stall_cyc; r0 = req_cyc;
    access(2'b00, 3'b000, 1'b1, 32'h3000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check("lw_data", done_rdata, 32'hDEAD_BEEF);
    check("lw_stall_cycles", 32'(stall_cyc - s0), 32'd2);
    check("lw_req_cycles", 32'(req_cyc - r0), 32'd1);
    check("lw_addr", last_addr, 32'h3000);

    // sh upper half; rdata_out must keep the last load value
    access(2'b10, 3'b000, 1'b0, 32'h1002, 32'h1234_CAFE, 32'h0, 0, 1'b0);
    check("sh_be", {28'b0, last_be}, 32'hC);
    check("sh_wdata", last_wdata, 32'hCAFE_CAFE);
    check("rdata_hold", rdata_out, 32'hDEAD_BEEF);

    // misaligned lw and sh
    r0 = req_cyc;
    req_valid = 1'b1; is_load = 1'b1; mem_write = 2'b00; mem_read = 3'b000; addr = 32'h3002;
    #1;
    check("lw_mis_pulse", {31'b0, ld_misaligned}, 32'd1);
    check("lw_mis_stall", {31'b0, stall}, 32'd0);
    check("lw_mis_st_flag", {31'b0, st_misaligned}, 32'd0);
    step();
    req_valid = 1'b0;
    #1;
    check("lw_mis_drop", {31'b0, ld_misaligned}, 32'd0);
    step();
    check("lw_mis_no_req", 32'(req_cyc - r0), 32'd0);
    req_valid = 1'b1; is_load = 1'b1; mem_write = 2'b10; addr = 32'h1001;
    #1;
    check("sh_mis_pulse", {31'b0, st_misaligned}, 32'd1);
    check("sh_mis_ld_flag", {31'b0, ld_misaligned}, 32'd0);
    check("sh_mis_stall", {31'b0, stall}, 32'd0);
    step();
    req_valid = 1'b0; mem_write = 2'b00;
    step();

    // stray ack while idle must not disturb the result
    v0 = rv_cnt;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0;
    step();
    check("idle_ack_rdata", rdata_out, 32'hDEAD_BEEF);
    check("idle_ack_rvalid", 32'(rv_cnt - v0), 32'd0);

    // timeout on a load
    r0 = req_cyc; t0 = to_cnt; x0 = xfers;
    access(2'b00, 3'b000, 1'b1, 32'h0500, 32'h0, 32'h5555_5555, -1, 1'b0);
    check("to_pulse", 32'(to_cnt - t0), 32'd1);
    check("to_busy_cycles", 32'(busy_cycles), 32'd256);
    check("to_req_cycles", 32'(req_cyc - r0), 32'd255);
    check("to_rdata", done_rdata, 32'h0);
    check("to_rvalid", {31'b0, done_rv}, 32'd1);
    check("to_xfers", 32'(xfers - x0), 32'd0);
    check("to_idle", {31'b0, stall}, 32'd0);

    // back-to-back lw with req_valid held through DONE
    x0 = xfers;
    access(2'b00, 3'b000, 1'b1, 32'h3000, 32'h0, 32'hAAAA_0001, 0, 1'b1);
    check("b2b_first", done_rdata, 32'hAAAA_0001);
    check("b2b_done_stall", {31'b0, done_stall}, 32'd0);
    access(2'b00, 3'b000, 1'b1, 32'h3004, 32'h0, 32'hBBBB_0002, 1, 1'b0);
    check("b2b_second", done_rdata, 32'hBBBB_0002);
    check("b2b_xfers", 32'(xfers - x0), 32'd2);

    // reset in the middle of BUSY
    v0 = rv_cnt;
    req_valid = 1'b1; is_load = 1'b1; mem_write = 2'b00; mem_read = 3'b000; addr = 32'h0040;
    bus_ack = 1'b0;
    step();
    step();
    check("mid_busy_req", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_abort_req", {31'b0, bus_req}, 32'd0);
    check("rst_abort_stall", {31'b0, stall}, 32'd0);
    check("rst_abort_addr", bus_addr, 32'h0);
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst_abort_rvalid", 32'(rv_cnt - v0), 32'd0);
    x0 = xfers;
    access(2'b11, 3'b000, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0, 0, 1'b0);
    check("post_rst_sw_be", {28'b0, last_be}, 32'hF);
    check("post_rst_sw_addr", last_addr, 32'h10);
    check("post_rst_sw_wdata", last_wdata, 32'h1234_5678);
    check("post_rst_sw_xfers", 32'(xfers - x0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
